// File: rtl/ball_pkg.sv
// -----------------------------------------------------------------------------
// ball_pkg
// Shared definitions for the ball motion controller slice:
//   - fixed-point scale (FIXED_POINT_MULTIPLIER / FP_SHIFT)
//   - per-frame FSM state encoding (ball_state_t)
//   - velocity / position / scan-delta types
//   - to_pixel(): fixed-point position -> 11-bit signed pixel coordinate
// -----------------------------------------------------------------------------
package ball_pkg;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FP_SHIFT               = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFLECT = 2'd1,
    MOVE    = 2'd2,
    DECAY   = 2'd3
  } ball_state_t;

  typedef logic signed [31:0] vel_t;
  typedef logic signed [31:0] pos_t;

  // Scan-to-ball offset. 16 bits covers an 11-bit unsigned scan coordinate
  // minus an 11-bit signed ball coordinate without overflow.
  typedef logic signed [15:0] delta_t;

  // Arithmetic shift keeps negative positions (ball partly off the left/top
  // edge) mapping to negative pixels.
  function automatic logic signed [10:0] to_pixel(input pos_t p);
    return 11'(p >>> FP_SHIFT);
  endfunction

endpackage

// File: rtl/hit_side_decoder.sv
// -----------------------------------------------------------------------------
// hit_side_decoder
// Purely combinational. Decides whether a collision seen at scan offset
// (dx, dy) inside the ball bounding box should reverse a velocity component.
// Only the outer quarter of the box on the side the ball is travelling
// towards reverses that component; centre hits and hits on the trailing side
// leave the velocity alone.
//
// Parameters:
//   BALL_SIZE  ball bounding-box side in pixels (multiple of 4)
// Ports:
//   dx, dy      in  offset of the scan pixel from the ball top-left
//   vx_neg/pos  in  sign of the X velocity (both low when vx == 0)
//   vy_neg/pos  in  sign of the Y velocity (both low when vy == 0)
//   flipX_req   out reverse the X velocity at the next frame update
//   flipY_req   out reverse the Y velocity at the next frame update
// -----------------------------------------------------------------------------
module hit_side_decoder
  import ball_pkg::*;
#(
  parameter int BALL_SIZE = 32
) (
  input  delta_t dx,
  input  delta_t dy,
  input  logic   vx_neg,
  input  logic   vx_pos,
  input  logic   vy_neg,
  input  logic   vy_pos,
  output logic   flipX_req,
  output logic   flipY_req
);

  localparam delta_t NEAR_EDGE = delta_t'(BALL_SIZE / 4);
  localparam delta_t FAR_EDGE  = delta_t'((3 * BALL_SIZE) / 4);

  // Signed compares: an offset left of / above the box counts as the near side.
  assign flipX_req = ((dx <  NEAR_EDGE) && vx_neg) ||
                     ((dx >= FAR_EDGE)  && vx_pos);
  assign flipY_req = ((dy <  NEAR_EDGE) && vy_neg) ||
                     ((dy >= FAR_EDGE)  && vy_pos);

endmodule

// File: rtl/ball_motion_controller.sv
// -----------------------------------------------------------------------------
// ball_motion_controller
// Per-ball kinematics engine. Collision pulses latch reflection flags; each
// frame start runs REFLECT -> MOVE -> DECAY and publishes the new top-left
// pixel coordinate. Cue shots load the velocity through a valid/ready
// handshake while the ball is at rest.
//
// Build option:
//   BALL_FRICTION_EN  defined   -> DECAY applies v -= v >>> FRICTION_SHIFT and
//                                  zeroes components with |v| < STOP_THRESHOLD
//                     undefined -> DECAY leaves the velocity untouched
//
// Parameters: INIT_X, INIT_Y (reset top-left, pixels), BALL_SIZE (pixels,
//   multiple of 4), FRICTION_SHIFT, STOP_THRESHOLD (fixed-point units).
// Ports:
//   clk, resetN         clock, asynchronous active-low reset
//   startOfFrame        one-cycle pulse per frame
//   SingleHitPulse      registered collision pulse (at most one per frame)
//   pixelX, pixelY      current scan coordinate
//   shot_valid/_ready   cue shot handshake; shot_vx/shot_vy velocity payload
//   topLeftX, topLeftY  ball top-left pixel coordinate
//   moving              either velocity component non-zero
// -----------------------------------------------------------------------------
module ball_motion_controller
  import ball_pkg::*;
#(
  parameter int INIT_X         = 320,
  parameter int INIT_Y         = 240,
  parameter int BALL_SIZE      = 32,
  parameter int FRICTION_SHIFT = 6,
  parameter int STOP_THRESHOLD = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               SingleHitPulse,
  input  logic        [10:0] pixelX,
  input  logic        [10:0] pixelY,
  input  logic               shot_valid,
  input  logic signed [15:0] shot_vx,
  input  logic signed [15:0] shot_vy,
  output logic               shot_ready,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               moving
);

`ifdef BALL_FRICTION_EN
  localparam bit FRICTION_EN = 1'b1;
`else
  localparam bit FRICTION_EN = 1'b0;
`endif

  localparam pos_t INIT_POS_X = pos_t'(INIT_X * FIXED_POINT_MULTIPLIER);
  localparam pos_t INIT_POS_Y = pos_t'(INIT_Y * FIXED_POINT_MULTIPLIER);
  localparam vel_t STOP_VEL   = vel_t'(STOP_THRESHOLD);

  ball_state_t state_q, state_d;
  pos_t        pos_x_q, pos_x_d;
  pos_t        pos_y_q, pos_y_d;
  vel_t        vel_x_q, vel_x_d;
  vel_t        vel_y_q, vel_y_d;
  logic        flip_x_q, flip_x_d;
  logic        flip_y_q, flip_y_d;

  delta_t      dx, dy;
  logic        flipX_req, flipY_req;
  logic        shot_fire;

  // One friction step for a single component. The floor of the arithmetic
  // shift means small positive speeds never decay, while small negative
  // speeds keep losing one unit per frame until they hit the threshold.
  function automatic vel_t friction_step(input vel_t v);
    vel_t r;
    r = v - (v >>> FRICTION_SHIFT);
    if ((r < STOP_VEL) && (r > -STOP_VEL)) begin
      r = '0;
    end
    return r;
  endfunction

  assign topLeftX   = to_pixel(pos_x_q);
  assign topLeftY   = to_pixel(pos_y_q);
  assign moving     = (vel_x_q != '0) || (vel_y_q != '0);
  assign shot_ready = (state_q == IDLE) && !moving;
  assign shot_fire  = shot_valid && shot_ready;

  // The hit pulse arrives one pixel clock after the pixel that caused it,
  // hence the extra -1 on the X offset only.
  assign dx = delta_t'({5'b0, pixelX}) - delta_t'(topLeftX) - delta_t'(1);
  assign dy = delta_t'({5'b0, pixelY}) - delta_t'(topLeftY);

  hit_side_decoder #(
    .BALL_SIZE (BALL_SIZE)
  ) u_hit_side_decoder (
    .dx        (dx),
    .dy        (dy),
    .vx_neg    (vel_x_q[31]),
    .vx_pos    (!vel_x_q[31] && (vel_x_q != '0)),
    .vy_neg    (vel_y_q[31]),
    .vy_pos    (!vel_y_q[31] && (vel_y_q != '0)),
    .flipX_req (flipX_req),
    .flipY_req (flipY_req)
  );

  // NOTE: next-state logic is fully combinational; every _d signal gets its
  // hold value first so no path through the case leaves it unassigned, which
  // would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vel_x_d  = vel_x_q;
    vel_y_d  = vel_y_q;
    flip_x_d = flip_x_q;
    flip_y_d = flip_y_q;

    case (state_q)
      IDLE: begin
        if (startOfFrame) begin
          state_d = REFLECT;
        end
      end
      REFLECT: begin
        if (flip_x_q) vel_x_d = -vel_x_q;
        if (flip_y_q) vel_y_d = -vel_y_q;
        flip_x_d = 1'b0;
        flip_y_d = 1'b0;
        state_d  = MOVE;
      end
      MOVE: begin
        // Wraps modulo 2^32; the table walls keep the ball far from that.
        pos_x_d = pos_x_q + vel_x_q;
        pos_y_d = pos_y_q + vel_y_q;
        state_d = DECAY;
      end
      DECAY: begin
        vel_x_d = FRICTION_EN ? friction_step(vel_x_q) : vel_x_q;
        vel_y_d = FRICTION_EN ? friction_step(vel_y_q) : vel_y_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A shot only fires in IDLE, so it never collides with the REFLECT or
    // DECAY velocity updates. With a coincident startOfFrame the new velocity
    // is what REFLECT and MOVE will see.
    if (shot_fire) begin
      vel_x_d  = vel_t'(shot_vx);
      vel_y_d  = vel_t'(shot_vy);
      flip_x_d = 1'b0;
      flip_y_d = 1'b0;
    end

    // Applied last so a hit during REFLECT survives the flag clear and is
    // honoured at the next frame.
    if (SingleHitPulse) begin
      if (flipX_req) flip_x_d = 1'b1;
      if (flipY_req) flip_y_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      pos_x_q  <= INIT_POS_X;
      pos_y_q  <= INIT_POS_Y;
      vel_x_q  <= '0;
      vel_y_q  <= '0;
      flip_x_q <= 1'b0;
      flip_y_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vel_x_q  <= vel_x_d;
      vel_y_q  <= vel_y_d;
      flip_x_q <= flip_x_d;
      flip_y_q <= flip_y_d;
    end
  end

endmodule
